// File: rtl/apb_ctrl_pkg.sv
// ============================================================================
// apb_ctrl_pkg : shared types and constants for the APB request arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int          DEF_AW      = 8;
  localparam int          DEF_DW      = 32;
  localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/apb_rr_picker.sv
// ============================================================================
// apb_rr_picker : combinational round-robin pick (rotate, encode, unrotate)
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_rr_picker #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   last_grant,
  output logic            found,
  output logic [IW-1:0]   idx
);

  // Operands never exceed 2*NREQ-2, so one conditional subtract replaces a modulo.
  function automatic int wrap_idx(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  int              start;
  int              off;
  logic [NREQ-1:0] rot;

  always_comb begin
    start = wrap_idx(int'(last_grant) + 1);
    rot   = '0;
    for (int j = 0; j < NREQ; j++) begin
      rot[j] = eligible[wrap_idx(start + j)];
    end

    found = 1'b0;
    off   = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = j;
      end
    end

    idx = IW'(wrap_idx(start + off));
  end

endmodule

`default_nettype wire

// File: rtl/apb_req_arbiter.sv
// ============================================================================
// apb_req_arbiter : round-robin sequencer sharing one apb_master among NREQ
//                   requesters; one data_valid pulse per transfer.
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_req_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int AW   = DEF_AW,
  parameter  int DW   = DEF_DW,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic             apb_clk,
  input  logic             apb_reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_en,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_dir,
  output logic [NREQ-1:0]    req_done,
  output logic               req_err,
  output logic [DW-1:0]      req_rdata,
  output logic [AW-1:0]      m_addr,
  output logic [DW-1:0]      m_data,
  output logic               m_data_dir,
  output logic               m_data_valid,
  input  logic [DW-1:0]      m_read_out_data,
  input  logic               m_transaction_done,
  input  logic               m_tranerr,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic [7:0]         err_cnt
);

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            dir_q, dir_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            sel_dir;

  apb_rr_picker #(.NREQ(NREQ)) u_picker (
    .eligible   (req_valid & req_en),
    .last_grant (last_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_dir  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
        sel_dir  = req_dir[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    addr_d       = addr_q;
    data_d       = data_q;
    dir_d        = dir_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    err_cnt_d    = err_cnt_q;
    m_data_valid = 1'b0;
    req_done     = '0;
    req_err      = 1'b0;
    req_rdata    = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          addr_d  = sel_addr;
          data_d  = sel_data;
          dir_d   = sel_dir;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_data_valid = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // A timeout report wins over a coincident completion.
        if (m_tranerr) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else if (m_transaction_done) begin
          rdata_d = dir_q ? '0 : m_read_out_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        for (int i = 0; i < NREQ; i++) begin
          req_done[i] = (grant_q == IW'(i));
        end
        req_err   = err_q;
        req_rdata = rdata_q;
        last_d    = grant_q;
        if (err_q && (err_cnt_q != ERR_CNT_MAX)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge apb_clk or negedge apb_reset_n) begin
    if (!apb_reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= IW'(NREQ - 1);
      addr_q    <= '0;
      data_q    <= '0;
      dir_q     <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_addr     = addr_q;
  assign m_data     = data_q;
  assign m_data_dir = dir_q;
  assign busy       = (state_q != ST_IDLE);
  assign grant_id   = grant_q;
  assign err_cnt    = err_cnt_q;

endmodule

`default_nettype wire

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter and sequencer that shares one `apb_master` system-side interface (addr/data/data_dir/data_valid in; read_out_data/transaction_done/apb_tranerr out) among NREQ requesters. It serialises requests and issues each as a single-cycle `data_valid` pulse. It holds the payload stable for the whole APB transfer and returns completion, read data and error to the granted requester. It sits between the system-level requesters and `apb_master`.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 8, address width (matches `apb_addr`)
- DW, 32, data width (matches `apb_wdata`/`apb_rdata`)

- apb_clk  in  1  clock, shared with `apb_master`
- apb_reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  NREQ  per-requester request
- req_en  in  NREQ  per-requester enable mask; 0 = never granted
- req_addr  in  NREQ*AW  packed addresses; slice i = requester i
- req_data  in  NREQ*DW  packed write data
- req_dir  in  NREQ  1 = write, 0 = read
- req_done  out  NREQ  one-cycle completion pulse to granted requester
- req_err  out  1  valid with req_done; 1 = transfer timed out in master
- req_rdata  out  DW  read data, valid with req_done (0 for writes and errors)
- m_addr  out  AW  to master `addr`
- m_data  out  DW  to master `data`
- m_data_dir  out  1  to master `data_dir`
- m_data_valid  out  1  to master `data_valid`
- m_read_out_data  in  DW  from master
- m_transaction_done  in  1  from master
- m_tranerr  in  1  from master `apb_tranerr`
- busy  out  1  state != IDLE
- grant_id  out  $clog2(NREQ)  current or last grant
- err_cnt  out  8  saturating count of errored transfers

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: eligible = req_valid & req_en. If nonzero, pick the first set bit searching from (last_grant+1) mod NREQ upward with wrap. Latch grant, addr, data and dir, then go to ISSUE.
- ISSUE: m_data_valid=1 for exactly one cycle, then go to WAIT. `apb_master` samples data_valid only in its IDLE; the single pulse prevents a re-issue.
- WAIT: m_addr/m_data/m_data_dir hold the latched payload and m_data_valid=0.
  - If m_tranerr=1: set err flag, go to RESP. m_tranerr takes priority if it coincides with m_transaction_done.
  - Else if m_transaction_done=1: latch m_read_out_data if read, else 0, then go to RESP.
- RESP: req_done[grant]=1, req_err and req_rdata driven from latches, last_grant<=grant, err_cnt+=err (saturates at 255). Then go to IDLE.
- The requester keeps req_valid high until its req_done. Withdrawal before grant is legal. After grant, req_valid/req_en/payload changes are ignored until RESP.
- Reset values: all outputs 0; state IDLE; last_grant=NREQ-1, so requester 0 wins first; err_cnt=0.
- Async reset mid-transfer aborts immediately with no req_done. The system must reset `apb_master` in the same window.

## Timing
- Request visible in IDLE cycle t: ISSUE at t+1 (m_data_valid high), WAIT from t+2.
- m_transaction_done seen in WAIT cycle d: req_done/req_rdata high in cycle d+1. IDLE at d+2; the next ISSUE is at d+3 at the earliest.
- Worst-case wait for an eligible requester is NREQ-1 transfers (round-robin fairness).
- m_* payload outputs are registered, with no combinational path from req_* to m_*.
- There is no internal timeout; WAIT exits only on m_transaction_done or m_tranerr.

## Structure
- Package `apb_ctrl_pkg`: state enum (IDLE/ISSUE/WAIT/RESP, 2 bits), default AW/DW constants, ERR_CNT_MAX=8'hFF.
- One sub-module `apb_rr_picker`: combinational, takes eligible[NREQ] and last_grant, returns found and idx. Rotate, priority-encode, unrotate.
- Payload mux, latches and FSM live in the top.

## Test plan
- Single write: req0 addr=4 data=10 dir=1 -> m_addr=4, m_data=10, m_data_dir=1; m_data_valid high exactly 1 cycle; req_done[0] 1 cycle; req_err=0.
- Read-back: req1 reads addr=4 after the above -> req_done[1] with req_rdata=10; read of addr=5 after write of 12 -> 12.
- Contention: req0..3 all valid from reset -> grant order 0,1,2,3. Re-assert req0 and req3 -> next order 0, then 3. No requester served twice while another eligible waits.
- Mask: req_en=4'b1101, req1 and req2 valid -> only req2 served; req1 stays pending and busy returns to 0.
- Error: force m_tranerr in WAIT -> req_err=1, req_rdata=0, err_cnt=1. 300 forced errors -> err_cnt=255.
- Reset mid-WAIT: drop apb_reset_n -> all outputs 0 asynchronously. After release with req2 and req0 valid -> req0 granted first.
